// File: rtl/vga_axil_slave_ctrl_if.sv
// vga_axil_slave_ctrl_if: AXI4-Lite channel bundle between the interconnect and the VGA slave controller
interface vga_axil_slave_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;
  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/vga_axil_slave_ctrl.sv
// vga_axil_slave_ctrl: AXI4-Lite slave to word-addressed native port with independent write/read FSMs
module vga_axil_slave_ctrl #(
  parameter int AXIL_DATA_WIDTH   = 32,
  parameter int AXIL_ADDR_WIDTH   = 32,
  parameter int NATIVE_ADDR_WIDTH = 10,
  parameter int ADDR_LIMIT        = 1024,
  parameter int READ_LATENCY      = 1
) (
  input  logic                         clk,
  input  logic                         arst,
  vga_axil_slave_ctrl_if.slave         axil,
  output logic                         write_en,
  output logic [NATIVE_ADDR_WIDTH-1:0] addr_write,
  output logic [AXIL_DATA_WIDTH-1:0]   data2native,
  output logic [AXIL_DATA_WIDTH/8-1:0] strb2native,
  output logic                         read_en,
  output logic [NATIVE_ADDR_WIDTH-1:0] addr_read,
  input  logic [AXIL_DATA_WIDTH-1:0]   native_rdata
);
  localparam int OFFSET = $clog2(AXIL_DATA_WIDTH/8);
  localparam logic [AXIL_ADDR_WIDTH-1:0] LIMIT = AXIL_ADDR_WIDTH'(ADDR_LIMIT);
  localparam logic [2:0] LAT = 3'(READ_LATENCY);
  typedef enum logic [1:0] {W_IDLE, W_EXEC, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;
  w_state_t w_state, w_next;
  r_state_t r_state, r_next;
  logic [AXIL_ADDR_WIDTH-1:0] aw_word, ar_word;
  logic aw_bad, ar_bad, aw_hs, w_hs, ar_hs, aw_done, w_done, w_go, w_err, r_err, r_hit;
  logic [2:0] r_cnt;
  always_comb begin
    aw_word = axil.awaddr >> OFFSET;
    ar_word = axil.araddr >> OFFSET;
    aw_bad  = (axil.awaddr[OFFSET-1:0] != '0) || (aw_word >= LIMIT);
    ar_bad  = (axil.araddr[OFFSET-1:0] != '0) || (ar_word >= LIMIT);
    aw_hs   = axil.awvalid && axil.awready;
    w_hs    = axil.wvalid && axil.wready;
    ar_hs   = axil.arvalid && axil.arready;
    w_go    = (w_state == W_IDLE) && (aw_done || aw_hs) && (w_done || w_hs);
    r_hit   = (r_state == R_WAIT) && (r_cnt == LAT);
  end
  always_ff @(posedge clk or posedge arst)
    if (arst) w_state <= W_IDLE;
    else w_state <= w_next;
  always_comb
    w_next = (w_state == W_IDLE) ? (w_go ? W_EXEC : W_IDLE) :
             (w_state == W_EXEC) ? W_RESP :
             (axil.bready ? W_IDLE : W_RESP);
  always_comb begin
    axil.awready = (w_state == W_IDLE) && !aw_done;
    axil.wready  = (w_state == W_IDLE) && !w_done;
    write_en     = (w_state == W_EXEC) && !w_err;
    axil.bvalid  = (w_state == W_RESP);
    axil.bresp   = (axil.bvalid && w_err) ? 2'b10 : 2'b00;
  end
  // Either channel may land first; the done flags remember which one already did.
  always_ff @(posedge clk or posedge arst)
    if (arst) begin
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      w_err       <= 1'b0;
      addr_write  <= '0;
      data2native <= '0;
      strb2native <= '0;
    end else begin
      if (aw_hs) begin
        aw_done    <= 1'b1;
        w_err      <= aw_bad;
        addr_write <= aw_word[NATIVE_ADDR_WIDTH-1:0];
      end
      if (w_hs) begin
        w_done      <= 1'b1;
        data2native <= axil.wdata;
        strb2native <= axil.wstrb;
      end
      if (w_go) begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end
    end
  always_ff @(posedge clk or posedge arst)
    if (arst) r_state <= R_IDLE;
    else r_state <= r_next;
  always_comb
    r_next = (r_state == R_IDLE) ? (axil.arvalid ? R_WAIT : R_IDLE) :
             (r_state == R_WAIT) ? (r_hit ? R_RESP : R_WAIT) :
             (axil.rready ? R_IDLE : R_RESP);
  always_comb begin
    axil.arready = (r_state == R_IDLE);
    read_en      = (r_state == R_WAIT) && (r_cnt == 3'd0) && !r_err;
    axil.rvalid  = (r_state == R_RESP);
    axil.rresp   = (axil.rvalid && r_err) ? 2'b10 : 2'b00;
  end
  // r_cnt == 0 is the read_en cycle; native data is taken when it reaches the latency.
  always_ff @(posedge clk or posedge arst)
    if (arst) begin
      r_err      <= 1'b0;
      r_cnt      <= 3'd0;
      addr_read  <= '0;
      axil.rdata <= '0;
    end else begin
      if (ar_hs) begin
        r_err     <= ar_bad;
        r_cnt     <= 3'd0;
        addr_read <= ar_word[NATIVE_ADDR_WIDTH-1:0];
      end else if (r_state == R_WAIT) r_cnt <= r_cnt + 3'd1;
      if (r_hit) axil.rdata <= r_err ? '0 : native_rdata;
    end
endmodule
